// File: rtl/jtag_tap_sync_if.sv
// ---------------------------------------------------------------------------
// jtag_tap_sync_if
//   The JTAG pin set between a host (master) and the TAP target (slave).
//   Signals:
//     tck  - test clock. The target treats it as data.
//     tms  - test mode select.
//     tdi  - test data in.
//     trst - test reset, active-low.
//     tdo  - test data out, driven by the target.
// ---------------------------------------------------------------------------
interface jtag_tap_sync_if;
  logic tck;
  logic tms;
  logic tdi;
  logic trst;
  logic tdo;

  modport master (output tck, output tms, output tdi, output trst, input tdo);
  modport slave  (input tck, input tms, input tdi, input trst, output tdo);
endinterface

// File: rtl/jtag_tap_sync.sv
// ---------------------------------------------------------------------------
// jtag_tap_sync
//   JTAG TAP target that runs entirely on the system clock. The JTAG pins
//   are sampled on clk_i, and TCK edges are found by comparing two samples.
//   An IEEE 1149.1 TAP controller then runs, with IDCODE, BYPASS and USER
//   data registers.
//   Ports:
//     clk_i, rst_i  - system clock and synchronous active-high reset
//     jtag          - JTAG pins (slave modport)
//     user_dr_i     - value captured into the USER DR in Capture-DR
//     user_dr_o     - USER register contents after Update-DR
//     user_update_o - one-cycle pulse when user_dr_o is written
//     tap_state_o   - current TAP state, in the IEEE encoding
// ---------------------------------------------------------------------------
module jtag_tap_sync #(
  parameter int          IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1234_5677,
  parameter int          USER_DR_WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  jtag_tap_sync_if.slave           jtag,
  input  logic [USER_DR_WIDTH-1:0] user_dr_i,
  output logic [USER_DR_WIDTH-1:0] user_dr_o,
  output logic                     user_update_o,
  output logic [3:0]               tap_state_o
);

  typedef enum logic [3:0] {
    TLR     = 4'hF, RTI     = 4'hC,
    SEL_DR  = 4'h7, CAP_DR  = 4'h6, SH_DR   = 4'h2, EX1_DR  = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR = 4'h0, UPD_DR  = 4'h5,
    SEL_IR  = 4'h4, CAP_IR  = 4'hE, SH_IR   = 4'hA, EX1_IR  = 4'h9,
    PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR  = 4'hD
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = 4'b0001;
  localparam logic [IR_WIDTH-1:0] IR_USER    = 4'b0010;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0101;

  // One shift register serves every DR. It is wide enough for IDCODE and for USER.
  localparam int DR_W  = (USER_DR_WIDTH > 32) ? USER_DR_WIDTH : 32;
  localparam int LEN_W = $clog2(DR_W);

  tap_state_e               state_q, state_d, state_nxt;
  logic                     tck_q, tck_d, tck_prev_q, tck_prev_d;
  logic                     tms_q, tms_d, tdi_q, tdi_d, trst_q, trst_d;
  logic [IR_WIDTH-1:0]      ir_shift_q, ir_shift_d, ir_q, ir_d;
  logic [DR_W-1:0]          dr_shift_q, dr_shift_d;
  logic [LEN_W-1:0]         dr_msb;
  logic                     tdo_q, tdo_d;
  logic [USER_DR_WIDTH-1:0] user_dr_q, user_dr_d;
  logic                     user_update_q, user_update_d;
  logic                     rise, fall;

  assign rise = tck_q & ~tck_prev_q;
  assign fall = ~tck_q & tck_prev_q;

  // Standard TMS transition table. This block only computes the target
  // state; the state register below advances only on a TCK rise.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      TLR:      state_nxt = tms_q ? TLR      : RTI;
      RTI:      state_nxt = tms_q ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = tms_q ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = tms_q ? EX1_DR   : SH_DR;
      SH_DR:    state_nxt = tms_q ? EX1_DR   : SH_DR;
      EX1_DR:   state_nxt = tms_q ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = tms_q ? EX2_DR   : PAUSE_DR;
      EX2_DR:   state_nxt = tms_q ? UPD_DR   : SH_DR;
      UPD_DR:   state_nxt = tms_q ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = tms_q ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = tms_q ? EX1_IR   : SH_IR;
      SH_IR:    state_nxt = tms_q ? EX1_IR   : SH_IR;
      EX1_IR:   state_nxt = tms_q ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = tms_q ? EX2_IR   : PAUSE_IR;
      EX2_IR:   state_nxt = tms_q ? UPD_IR   : SH_IR;
      UPD_IR:   state_nxt = tms_q ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the
    // branches below leaves a value unassigned and infers a latch.
    tck_d         = jtag.tck;
    tck_prev_d    = tck_q;
    tms_d         = jtag.tms;
    tdi_d         = jtag.tdi;
    trst_d        = jtag.trst;
    state_d       = state_q;
    ir_shift_d    = ir_shift_q;
    ir_d          = ir_q;
    dr_shift_d    = dr_shift_q;
    tdo_d         = tdo_q;
    user_dr_d     = user_dr_q;
    user_update_d = 1'b0;

    // Active DR length minus one. Any unknown instruction code acts as BYPASS.
    if (ir_q == IR_IDCODE)    dr_msb = LEN_W'(31);
    else if (ir_q == IR_USER) dr_msb = LEN_W'(USER_DR_WIDTH - 1);
    else                      dr_msb = '0;

    if (!trst_q) begin
      // TRST overrides any TCK edge seen in the same cycle.
      state_d = TLR;
      ir_d    = IR_IDCODE;
      tdo_d   = 1'b0;
    end else if (rise) begin
      unique case (state_q)
        CAP_IR: ir_shift_d = IR_CAPTURE;
        SH_IR:  ir_shift_d = {tdi_q, ir_shift_q[IR_WIDTH-1:1]};
        CAP_DR: begin
          if (ir_q == IR_IDCODE)    dr_shift_d = DR_W'(IDCODE_VALUE);
          else if (ir_q == IR_USER) dr_shift_d = DR_W'(user_dr_i);
          else                      dr_shift_d = '0;
        end
        SH_DR: begin
          dr_shift_d         = dr_shift_q >> 1;
          dr_shift_d[dr_msb] = tdi_q;
        end
        default: ;
      endcase
      state_d = state_nxt;
      if (state_nxt == TLR) ir_d = IR_IDCODE;
    end else if (fall) begin
      if (state_q == SH_IR)      tdo_d = ir_shift_q[0];
      else if (state_q == SH_DR) tdo_d = dr_shift_q[0];
      else                       tdo_d = 1'b0;
      if (state_q == UPD_IR) ir_d = ir_shift_q;
      if (state_q == UPD_DR && ir_q == IR_USER) begin
        user_dr_d     = dr_shift_q[USER_DR_WIDTH-1:0];
        user_update_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples its pre-edge _d value no matter what order the statements are in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= TLR;
      tck_q         <= 1'b0;
      tck_prev_q    <= 1'b0;
      tms_q         <= 1'b0;
      tdi_q         <= 1'b0;
      trst_q        <= 1'b1;
      ir_shift_q    <= '0;
      ir_q          <= IR_IDCODE;
      dr_shift_q    <= '0;
      tdo_q         <= 1'b0;
      user_dr_q     <= '0;
      user_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tck_q         <= tck_d;
      tck_prev_q    <= tck_prev_d;
      tms_q         <= tms_d;
      tdi_q         <= tdi_d;
      trst_q        <= trst_d;
      ir_shift_q    <= ir_shift_d;
      ir_q          <= ir_d;
      dr_shift_q    <= dr_shift_d;
      tdo_q         <= tdo_d;
      user_dr_q     <= user_dr_d;
      user_update_q <= user_update_d;
    end
  end

  assign jtag.tdo      = tdo_q;
  assign user_dr_o     = user_dr_q;
  assign user_update_o = user_update_q;
  assign tap_state_o   = state_q;

endmodule

// File: tb/tb_jtag_tap_sync.sv
// ---------------------------------------------------------------------------
// tb_jtag_tap_sync
//   Directed bench for jtag_tap_sync. It acts as the JTAG host, bit-banging
//   TCK with high and low phases of three clk cycles each. The expected
//   values are worked out by hand.
// ---------------------------------------------------------------------------
module tb_jtag_tap_sync;

  localparam logic [31:0] IDCODE = 32'h1234_5677;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] user_dr_i;
  logic [31:0] user_dr_o;
  logic        user_update_o;
  logic [3:0]  tap_state_o;

  int          checks = 0;
  int          errors = 0;
  int          upd_cnt = 0;
  logic [31:0] upd_val = '0;

  always #5 clk = ~clk;

  jtag_tap_sync_if jtag ();

  jtag_tap_sync #(
    .IR_WIDTH      (4),
    .IDCODE_VALUE  (IDCODE),
    .USER_DR_WIDTH (32)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .jtag          (jtag),
    .user_dr_i     (user_dr_i),
    .user_dr_o     (user_dr_o),
    .user_update_o (user_update_o),
    .tap_state_o   (tap_state_o)
  );

  // Count cycles with user_update_o high. Also record user_dr_o in those same cycles.
  always @(negedge clk) begin
    if (user_update_o === 1'b1) begin
      upd_cnt++;
      upd_val = user_dr_o;
    end
  end

  // One TCK period. The task returns on a negedge after the fall actions have settled.
  task automatic tck_cycle(input logic tms, input logic tdi);
    @(negedge clk);
    jtag.tms = tms;
    jtag.tdi = tdi;
    jtag.tck = 1'b1;
    repeat (3) @(negedge clk);
    jtag.tck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Apply a TMS sequence (LSB first) with TDI held at 0.
  task automatic tms_walk(input logic [7:0] seq, input int n);
    for (int i = 0; i < n; i++) tck_cycle(seq[i], 1'b0);
  endtask

  // Shift n bits from a Shift state. TDO is read before each rise, LSB
  // first. TMS is raised on the last bit to leave the shift state.
  task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = jtag.tdo;
      tck_cycle(i == n - 1, din[i]);
    end
  endtask

  // Run-Test/Idle -> IR scan -> Update-IR -> Run-Test/Idle.
  task automatic load_ir(input logic [3:0] code, output logic [3:0] cap);
    logic [63:0] d;
    tms_walk(8'b0000_0011, 4);
    shift_bits(4, {60'd0, code}, d);
    tms_walk(8'b0000_0001, 2);
    cap = d[3:0];
  endtask

  // Run-Test/Idle -> DR scan -> Update-DR -> Run-Test/Idle.
  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    tms_walk(8'b0000_0001, 3);
    shift_bits(n, din, dout);
    tms_walk(8'b0000_0001, 2);
  endtask

  task automatic test_reset();
    jtag.tck = 1'b0; jtag.tms = 1'b1; jtag.tdi = 1'b0; jtag.trst = 1'b1;
    user_dr_i = 32'hA5A5_0F0F;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tap_state_o !== 4'hF) begin errors++; $display("FAIL reset_state got %h want F", tap_state_o); end
    checks++; if (jtag.tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b want 0", jtag.tdo); end
    checks++; if (user_dr_o !== 32'h0) begin errors++; $display("FAIL reset_user_dr got %h want 0", user_dr_o); end
    checks++; if (user_update_o !== 1'b0) begin errors++; $display("FAIL reset_update got %b want 0", user_update_o); end
  endtask

  task automatic test_idcode();
    logic        tms_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  exp_st  [4] = '{4'hC, 4'h7, 4'h6, 4'h2};
    logic [63:0] d;
    for (int i = 0; i < 4; i++) begin
      tck_cycle(tms_seq[i], 1'b0);
      checks++;
      if (tap_state_o !== exp_st[i]) begin
        errors++; $display("FAIL idcode_walk[%0d] got %h want %h", i, tap_state_o, exp_st[i]);
      end
    end
    shift_bits(32, 64'd0, d);
    checks++; if (d[31:0] !== IDCODE) begin errors++; $display("FAIL idcode_shift got %h want %h", d[31:0], IDCODE); end
    checks++; if (tap_state_o !== 4'h1) begin errors++; $display("FAIL idcode_exit got %h want 1", tap_state_o); end
    tms_walk(8'b0000_0001, 2);
    checks++; if (tap_state_o !== 4'hC) begin errors++; $display("FAIL idcode_rti got %h want C", tap_state_o); end
  endtask

  task automatic test_ir_bypass();
    logic [3:0]  cap;
    logic [63:0] d;
    load_ir(4'b1111, cap);
    checks++; if (cap !== 4'b0101) begin errors++; $display("FAIL ir_capture got %b want 0101", cap); end
    // TDI 1,0,1,1 comes back as the captured 0, then TDI one TCK late.
    scan_dr(4, 64'b1101, d);
    checks++; if (d[3:0] !== 4'b1010) begin errors++; $display("FAIL bypass_shift got %b want 1010", d[3:0]); end
    checks++; if (upd_cnt !== 0) begin errors++; $display("FAIL bypass_no_update got %0d want 0", upd_cnt); end
  endtask

  task automatic test_user();
    logic [3:0]  cap;
    logic [63:0] d;
    user_dr_i = 32'hA5A5_0F0F;
    load_ir(4'b0010, cap);
    checks++; if (cap !== 4'b0101) begin errors++; $display("FAIL user_ir_capture got %b want 0101", cap); end
    scan_dr(32, 64'hDEAD_BEEF, d);
    checks++; if (d[31:0] !== 32'hA5A5_0F0F) begin errors++; $display("FAIL user_capture got %h want A5A50F0F", d[31:0]); end
    checks++; if (user_dr_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL user_dr_o got %h want DEADBEEF", user_dr_o); end
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL user_update_cycles got %0d want 1", upd_cnt); end
    checks++; if (upd_val !== 32'hDEAD_BEEF) begin errors++; $display("FAIL user_update_value got %h want DEADBEEF", upd_val); end
  endtask

  task automatic test_trst();
    logic [63:0] d;
    // The IR still holds USER, so TDO carries bit 0 of user_dr_i once in Shift-DR.
    tms_walk(8'b0000_0001, 3);
    checks++; if (tap_state_o !== 4'h2) begin errors++; $display("FAIL trst_pre_state got %h want 2", tap_state_o); end
    checks++; if (jtag.tdo !== 1'b1) begin errors++; $display("FAIL trst_pre_tdo got %b want 1", jtag.tdo); end
    // TRST low for two cycles, with a TCK rise that must be ignored.
    @(negedge clk);
    jtag.trst = 1'b0; jtag.tms = 1'b0; jtag.tck = 1'b1;
    repeat (2) @(negedge clk);
    jtag.trst = 1'b1;
    repeat (2) @(negedge clk);
    jtag.tck = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tap_state_o !== 4'hF) begin errors++; $display("FAIL trst_state got %h want F", tap_state_o); end
    checks++; if (jtag.tdo !== 1'b0) begin errors++; $display("FAIL trst_tdo got %b want 0", jtag.tdo); end
    checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL trst_no_update got %0d want 1", upd_cnt); end
    tck_cycle(1'b0, 1'b0);
    scan_dr(32, 64'd0, d);
    checks++; if (d[31:0] !== IDCODE) begin errors++; $display("FAIL trst_idcode got %h want %h", d[31:0], IDCODE); end
  endtask

  task automatic test_tms_reset();
    logic [3:0]  cap;
    logic [63:0] d;
    load_ir(4'b0010, cap);
    // Walk to Pause-IR. Update-IR then loads the shifted 0010 (USER) on
    // the way to TLR, and TLR must discard it.
    tms_walk(8'b0001_0011, 6);
    checks++; if (tap_state_o !== 4'hB) begin errors++; $display("FAIL tmsrst_pause got %h want B", tap_state_o); end
    tms_walk(8'b0001_1111, 5);
    checks++; if (tap_state_o !== 4'hF) begin errors++; $display("FAIL tmsrst_state got %h want F", tap_state_o); end
    tck_cycle(1'b0, 1'b0);
    scan_dr(32, 64'd0, d);
    checks++; if (d[31:0] !== IDCODE) begin errors++; $display("FAIL tmsrst_idcode got %h want %h", d[31:0], IDCODE); end
    checks++; if (user_dr_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL tmsrst_user_dr got %h want DEADBEEF", user_dr_o); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  cap;
    logic [63:0] d;
    // 0111 is not a defined instruction, so it must act as BYPASS.
    load_ir(4'b0111, cap);
    checks++; if (cap !== 4'b0101) begin errors++; $display("FAIL b2b_ir_capture got %b want 0101", cap); end
    scan_dr(4, 64'b1101, d);
    checks++; if (d[3:0] !== 4'b1010) begin errors++; $display("FAIL b2b_scan1 got %b want 1010", d[3:0]); end
    scan_dr(4, 64'b0110, d);
    checks++; if (d[3:0] !== 4'b1100) begin errors++; $display("FAIL b2b_scan2 got %b want 1100", d[3:0]); end
  endtask

  task automatic test_sync_reset();
    logic [3:0]  cap;
    logic [63:0] d;
    int          cnt_before;
    load_ir(4'b0010, cap);
    tms_walk(8'b0000_0001, 3);
    @(negedge clk);
    jtag.tms = 1'b0; jtag.tdi = 1'b1; jtag.tck = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (jtag.tdo !== 1'b1) begin errors++; $display("FAIL srst_pre_tdo got %b want 1", jtag.tdo); end
    cnt_before = upd_cnt;
    // Keep TMS high so the edge seen after release leaves the TAP in TLR.
    jtag.tms = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tap_state_o !== 4'hF) begin errors++; $display("FAIL srst_state got %h want F", tap_state_o); end
    checks++; if (jtag.tdo !== 1'b0) begin errors++; $display("FAIL srst_tdo got %b want 0", jtag.tdo); end
    checks++; if (user_dr_o !== 32'h0) begin errors++; $display("FAIL srst_user_dr got %h want 0", user_dr_o); end
    checks++; if (user_update_o !== 1'b0) begin errors++; $display("FAIL srst_update got %b want 0", user_update_o); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    jtag.tck = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tap_state_o !== 4'hF) begin errors++; $display("FAIL srst_fall_state got %h want F", tap_state_o); end
    checks++; if (jtag.tdo !== 1'b0) begin errors++; $display("FAIL srst_fall_tdo got %b want 0", jtag.tdo); end
    checks++; if (upd_cnt !== cnt_before) begin errors++; $display("FAIL srst_fall_update got %0d want %0d", upd_cnt, cnt_before); end
    tck_cycle(1'b0, 1'b0);
    scan_dr(32, 64'd0, d);
    checks++; if (d[31:0] !== IDCODE) begin errors++; $display("FAIL srst_idcode got %h want %h", d[31:0], IDCODE); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_bypass();
    test_user();
    test_trst();
    test_tms_reset();
    test_back_to_back();
    test_sync_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
